// File: rtl/video_pkg.sv
// Shared frame-buffer / sprite geometry, colour key and blitter types.
package video_pkg;

    localparam int RGB_W         = 6;
    localparam int FB_W          = 80;
    localparam int FB_H          = 60;
    localparam int FB_ADDR_BITS  = 13;
    localparam int SPR_W         = 8;
    localparam int SPR_H         = 8;
    localparam int NUM_SPRITES   = 4;
    localparam int ROM_ADDR_BITS = $clog2(NUM_SPRITES * SPR_W * SPR_H);
    localparam int SPR_ID_W      = $clog2(NUM_SPRITES);
    localparam int POS_X_W       = 7;
    localparam int POS_Y_W       = 6;
    // One spare bit so a sprite hanging off the edge is detected, not wrapped.
    localparam int DX_W          = POS_X_W + 1;
    localparam int DY_W          = POS_Y_W + 1;

    localparam logic [RGB_W-1:0] KEY = 6'b000000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } blit_state_t;

    typedef struct packed {
        logic [SPR_ID_W-1:0] sprite_id;
        logic [POS_X_W-1:0]  pos_x;
        logic [POS_Y_W-1:0]  pos_y;
    } blit_req_t;

    typedef struct packed {
        logic [DX_W-1:0] dx;
        logic [DY_W-1:0] dy;
    } pix_tag_t;

endpackage

// File: rtl/sprite_blitter_wr.sv
// Write stage: carries each pixel's destination alongside the ROM read,
// then drops colour-key and off-screen pixels before the frame-buffer port.
module sprite_blitter_wr
    import video_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    issue,
    input  pix_tag_t                tag,
    input  logic [RGB_W-1:0]        rom_data,
    output logic                    fb_we,
    output logic [FB_ADDR_BITS-1:0] fb_addr,
    output logic [RGB_W-1:0]        fb_wdata
);
    localparam int STAGES = 1;

    // [0] aligned with rom_addr, [STAGES] aligned with rom_data.
    logic [STAGES:0]         vld_pipe;
    pix_tag_t                tag_pipe [STAGES+1];
    logic                    in_range;
    logic [FB_ADDR_BITS-1:0] addr_nxt;

    assign in_range = (tag_pipe[STAGES].dx < DX_W'(FB_W)) &&
                      (tag_pipe[STAGES].dy < DY_W'(FB_H));
    assign addr_nxt = FB_ADDR_BITS'(tag_pipe[STAGES].dy) * FB_ADDR_BITS'(FB_W) +
                      FB_ADDR_BITS'(tag_pipe[STAGES].dx);

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int i = 0; i <= STAGES; i++) tag_pipe[i] <= '0;
            fb_we    <= 1'b0;
            fb_addr  <= '0;
            fb_wdata <= '0;
        end else begin
            vld_pipe    <= {vld_pipe[STAGES-1:0], issue};
            tag_pipe[0] <= tag;
            for (int i = 1; i <= STAGES; i++) tag_pipe[i] <= tag_pipe[i-1];
            fb_we <= vld_pipe[STAGES] && (rom_data != KEY) && in_range;
            if (vld_pipe[STAGES]) begin
                fb_addr  <= addr_nxt;
                fb_wdata <= rom_data;
            end
        end
    end

endmodule

// File: rtl/sprite_blitter.sv
// Copies one sprite from the sprite ROM into the frame buffer at a latched
// coarse-grid position; the write stage handles colour key and clipping.
module sprite_blitter
    import video_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [SPR_ID_W-1:0]      sprite_id,
    input  logic [POS_X_W-1:0]       pos_x,
    input  logic [POS_Y_W-1:0]       pos_y,
    output logic                     busy,
    output logic                     done,
    output logic [ROM_ADDR_BITS-1:0] rom_addr,
    input  logic [RGB_W-1:0]         rom_data,
    output logic                     fb_we,
    output logic [FB_ADDR_BITS-1:0]  fb_addr,
    output logic [RGB_W-1:0]         fb_wdata
);
    localparam int CW      = $clog2(SPR_W);
    localparam int RW      = $clog2(SPR_H);
    localparam int SPR_PIX = SPR_W * SPR_H;

    blit_state_t              state, state_nxt;
    blit_req_t                req;
    logic [CW-1:0]            col;
    logic [RW-1:0]            row;
    logic                     issued_all;
    logic                     issue;
    logic [ROM_ADDR_BITS-1:0] rom_addr_nxt;
    pix_tag_t                 tag;

    // RUN lasts one cycle past the final issue so that address is on the bus
    // while the ROM reads it; FLUSH then covers the last write register.
    assign issue = (state == ST_RUN) && !issued_all;

    // Deliberately kept at ROM width: an out-of-range sprite id just wraps.
    assign rom_addr_nxt = ROM_ADDR_BITS'(req.sprite_id) * ROM_ADDR_BITS'(SPR_PIX) +
                          ROM_ADDR_BITS'(row) * ROM_ADDR_BITS'(SPR_W) +
                          ROM_ADDR_BITS'(col);

    assign tag.dx = DX_W'(req.pos_x) + DX_W'(col);
    assign tag.dy = DY_W'(req.pos_y) + DY_W'(row);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            req        <= '0;
            col        <= '0;
            row        <= '0;
            issued_all <= 1'b0;
            rom_addr   <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && start) begin
                req        <= '{sprite_id: sprite_id, pos_x: pos_x, pos_y: pos_y};
                col        <= '0;
                row        <= '0;
                issued_all <= 1'b0;
            end else if (issue) begin
                rom_addr <= rom_addr_nxt;
                if (col == CW'(SPR_W - 1)) begin
                    col <= '0;
                    if (row == RW'(SPR_H - 1)) begin
                        row        <= '0;
                        issued_all <= 1'b1;
                    end else begin
                        row <= row + 1'b1;
                    end
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN: begin
                busy = 1'b1;
                if (issued_all) state_nxt = ST_FLUSH;
            end
            ST_FLUSH: begin
                busy      = 1'b1;
                state_nxt = ST_DONE;
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default:  state_nxt = ST_IDLE;
        endcase
    end

    sprite_blitter_wr u_wr (
        .clk      (clk),
        .rst      (rst),
        .issue    (issue),
        .tag      (tag),
        .rom_data (rom_data),
        .fb_we    (fb_we),
        .fb_addr  (fb_addr),
        .fb_wdata (fb_wdata)
    );

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with a behavioural sprite ROM and a
// write monitor; expected pixels come from hand-built sprite contents.
module tb_sprite_blitter;
    import video_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  sprite_id = '0;
    logic [6:0]  pos_x = '0;
    logic [5:0]  pos_y = '0;
    logic        busy, done, fb_we;
    logic [7:0]  rom_addr;
    logic [5:0]  rom_data;
    logic [12:0] fb_addr;
    logic [5:0]  fb_wdata;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sprite_id (sprite_id),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .busy      (busy),
        .done      (done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fb_we     (fb_we),
        .fb_addr   (fb_addr),
        .fb_wdata  (fb_wdata)
    );

    logic [5:0] rom [256];
    always @(posedge clk) rom_data <= rom[rom_addr];

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int wr_cnt, done_cnt, done_cyc, first_we, last_we, oob_cnt, done_busy;
    int wq_addr[$], wq_data[$], ex_addr[$], ex_data[$];

    // Sample just after each active edge.
    always @(posedge clk) begin
        #1;
        cyc++;
        if (fb_we) begin
            wq_addr.push_back(int'(fb_addr));
            wq_data.push_back(int'(fb_wdata));
            wr_cnt++;
            if (first_we < 0) first_we = cyc;
            last_we = cyc;
            if (int'(fb_addr) >= 4800) oob_cnt++;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            if (busy) done_busy++;
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        wq_addr.delete(); wq_data.delete();
        wr_cnt = 0; done_cnt = 0; done_cyc = -1;
        first_we = -1; last_we = -1; oob_cnt = 0; done_busy = 0;
    endtask

    task automatic build_exp(input int id, input int x, input int y);
        ex_addr.delete(); ex_data.delete();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                if (x + c < 80 && y + r < 60 && rom[id*64 + r*8 + c] != 6'h00) begin
                    ex_addr.push_back((y + r) * 80 + x + c);
                    ex_data.push_back(int'(rom[id*64 + r*8 + c]));
                end
    endtask

    task automatic cmp_writes(input string tag);
        int bad = 0;
        chk({tag, "_nwr"}, wq_addr.size(), ex_addr.size());
        for (int i = 0; i < wq_addr.size() && i < ex_addr.size(); i++)
            if (wq_addr[i] != ex_addr[i] || wq_data[i] != ex_data[i]) bad++;
        chk({tag, "_pix"}, bad, 0);
    endtask

    task automatic pulse_start(input int id, input int x, input int y, output int ts);
        @(negedge clk);
        sprite_id = 2'(id); pos_x = 7'(x); pos_y = 6'(y); start = 1'b1;
        ts = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (done_cnt == 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) chk({tag, "_timeout"}, 0, 1);
    endtask

    int ts;

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 6'h15;
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++) begin
                rom[64 + r*8 + c]  = ((r + c) % 2 == 1) ? 6'h3F : 6'h00;
                rom[128 + r*8 + c] = 6'h00;
                rom[192 + r*8 + c] = 6'(r*8 + c + 1);
            end
        clr_mon();

        // Reset and idle
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_we", int'(fb_we), 0);
        chk("rst_addr", int'(fb_addr), 0);
        chk("rst_wdata", int'(fb_wdata), 0);
        chk("rst_romaddr", int'(rom_addr), 0);
        rst = 1'b0;
        clr_mon();
        repeat (5) @(negedge clk);
        chk("idle_busy", int'(busy), 0);
        chk("idle_wr", wr_cnt, 0);
        chk("idle_done", done_cnt, 0);

        // Basic solid sprite
        clr_mon(); build_exp(0, 10, 5);
        pulse_start(0, 10, 5, ts);
        chk("basic_busy", int'(busy), 1);
        wait_done("basic", 200);
        repeat (3) @(negedge clk);
        chk("basic_lat", done_cyc - ts, 67);
        chk("basic_ndone", done_cnt, 1);
        chk("basic_done_busy", done_busy, 0);
        chk("basic_wr", wr_cnt, 64);
        chk("basic_span", last_we - first_we + 1, 64);
        chk("basic_first", (wq_addr.size() > 0) ? wq_addr[0] : -1, 410);
        chk("basic_last", (wq_addr.size() > 63) ? wq_addr[63] : -1, 977);
        chk("basic_data", (wq_data.size() > 0) ? wq_data[0] : -1, 'h15);
        chk("basic_idle", int'(busy), 0);
        cmp_writes("basic");

        // Checkerboard transparency
        clr_mon(); build_exp(1, 20, 10);
        pulse_start(1, 20, 10, ts);
        wait_done("key", 200);
        repeat (3) @(negedge clk);
        chk("key_lat", done_cyc - ts, 67);
        chk("key_wr", wr_cnt, 32);
        chk("key_first", (wq_addr.size() > 0) ? wq_addr[0] : -1, 821);
        cmp_writes("key");

        // Right/bottom clipping
        clr_mon(); build_exp(3, 76, 58);
        pulse_start(3, 76, 58, ts);
        wait_done("clip", 200);
        repeat (3) @(negedge clk);
        chk("clip_lat", done_cyc - ts, 67);
        chk("clip_wr", wr_cnt, 8);
        chk("clip_oob", oob_cnt, 0);
        chk("clip_first", (wq_addr.size() > 0) ? wq_addr[0] : -1, 4716);
        chk("clip_last", (wq_addr.size() > 7) ? wq_addr[7] : -1, 4799);
        cmp_writes("clip");

        // All-key sprite
        clr_mon();
        pulse_start(2, 0, 0, ts);
        wait_done("allkey", 200);
        repeat (3) @(negedge clk);
        chk("allkey_lat", done_cyc - ts, 67);
        chk("allkey_wr", wr_cnt, 0);
        chk("allkey_ndone", done_cnt, 1);

        // Second start while busy is dropped
        clr_mon(); build_exp(0, 10, 5);
        pulse_start(0, 10, 5, ts);
        repeat (18) @(negedge clk);
        pulse_start(1, 30, 30, done_busy);
        done_busy = 0;
        wait_done("busy", 200);
        repeat (80) @(negedge clk);
        chk("busy_lat", done_cyc - ts, 67);
        chk("busy_ndone", done_cnt, 1);
        chk("busy_idle", int'(busy), 0);
        cmp_writes("busy");

        // Start during the DONE cycle is ignored
        clr_mon();
        pulse_start(3, 0, 0, ts);
        wait_done("dstart", 200);
        chk("dstart_in_done", int'(done), 1);
        start = 1'b1; pos_x = 7'd40;
        @(negedge clk);
        start = 1'b0;
        chk("dstart_busy", int'(busy), 0);
        repeat (5) @(negedge clk);
        chk("dstart_busy_later", int'(busy), 0);
        chk("dstart_ndone", done_cnt, 1);

        // Reset mid-blit, then a clean blit
        clr_mon();
        pulse_start(0, 10, 5, ts);
        repeat (29) @(negedge clk);
        chk("mid_we_pre", int'(fb_we), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_we", int'(fb_we), 0);
        chk("mid_busy", int'(busy), 0);
        rst = 1'b0;
        repeat (80) @(negedge clk);
        chk("mid_ndone", done_cnt, 0);
        clr_mon(); build_exp(0, 10, 5);
        pulse_start(0, 10, 5, ts);
        wait_done("post", 200);
        repeat (3) @(negedge clk);
        chk("post_lat", done_cyc - ts, 67);
        chk("post_wr", wr_cnt, 64);
        cmp_writes("post");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
